mod_updown_counter: RTL and testbench
=====================================

MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the counter width in bits (legal values 1..32).
REQ-002 The block SHALL have parameter MODULUS, default 2**WIDTH, giving the count range 0..MODULUS-1 (legal values 2..2**WIDTH).
REQ-003 The block SHALL have parameter SATURATE, default 0: 0 means the count wraps at the range ends, 1 means it holds at the range ends.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-006 The block SHALL have port en, input, 1 bit: count enable.
REQ-007 The block SHALL have port up, input, 1 bit: count direction (1 = increment, 0 = decrement).
REQ-008 The block SHALL have port load, input, 1 bit: parallel load strobe.
REQ-009 The block SHALL have port load_val, input, WIDTH bits: the parallel load value.
REQ-010 The block SHALL have port clr_ovf, input, 1 bit: clears the sticky overflow flag.
REQ-011 The block SHALL have port q, output, WIDTH bits: the registered count.
REQ-012 The block SHALL have port tc, output, 1 bit: combinational terminal-count lookahead, used to cascade counters.
REQ-013 The block SHALL have port ovf, output, 1 bit: registered sticky overflow/underflow flag.

Function
REQ-014 The block SHALL apply this per-edge priority: reset > load > en > hold.
REQ-015 load=1 SHALL set q to load_val on the next edge; if load_val >= MODULUS, q SHALL instead load MODULUS-1.
REQ-016 load=1 SHALL NOT cause a terminal event and SHALL NOT set ovf, even when en=1 in the same cycle.
REQ-017 en=1, up=1, q<MODULUS-1 SHALL give q+1; en=1, up=0, q>0 SHALL give q-1.
REQ-018 en=1, up=1, q=MODULUS-1 SHALL be a terminal event: with SATURATE=0 q goes to 0; with SATURATE=1 q holds.
REQ-019 en=1, up=0, q=0 SHALL be a terminal event: with SATURATE=0 q goes to MODULUS-1; with SATURATE=1 q holds.
REQ-020 tc SHALL equal en & ~load & ((up & q==MODULUS-1) | (~up & q==0)), with zero cycles of latency.
REQ-021 tc SHALL be 0 while reset=1.
REQ-022 ovf SHALL be set on the edge following a terminal event and SHALL stay set until cleared.
REQ-023 clr_ovf=1 SHALL clear ovf on the next edge.
REQ-024 If a terminal event and clr_ovf=1 occur in the same cycle, ovf SHALL end up set (set wins).
REQ-025 A change of up SHALL take effect in the same cycle, with no pipeline delay.
REQ-026 en=0 with load=0 SHALL hold q and ovf, apart from any clr_ovf action.
REQ-027 All next-value arithmetic SHALL be done in WIDTH+1 bits, so the terminal compare does not depend on natural binary overflow when MODULUS < 2**WIDTH.

Reset
REQ-028 reset=1 at a rising edge SHALL force q=0 and ovf=0, overriding load, en and clr_ovf.
REQ-029 Reset asserted mid-count SHALL take effect at the next edge, leaving no residual state.
REQ-030 Counting SHALL resume on the first edge after reset deasserts.

Structure
REQ-031 Package counter_pkg SHALL hold the SATURATE mode constants (CNT_WRAP=0, CNT_SAT=1) and the MODULUS legality-check function.
REQ-032 Sub-module mod_next_value (combinational: q, up, en, load, load_val -> next q, terminal flag) SHALL be the only sub-module.
REQ-033 The register stage SHALL be in the top module.
REQ-034 An elaboration-time check SHALL reject MODULUS < 2 or MODULUS > 2**WIDTH.

Verification
REQ-035 WIDTH=4, MODULUS=10, SATURATE=0, up=1, en=1, 12 clocks from reset -> q = 1..9, 0, 1, 2; tc=1 only while q=9; ovf rises after the 9->0 edge.
REQ-036 WIDTH=4, MODULUS=10, up=0, en=1 from q=0 -> q goes 9, 8; tc=1 while q=0; ovf set.
REQ-037 SATURATE=1, MODULUS=10, up=1, q=9, en=1 for 3 clocks -> q holds 9; tc=1 each cycle; ovf=1.
REQ-038 load=1, load_val=13, MODULUS=10, en=1, up=1 -> q=9 next edge; ovf unchanged; tc=0 during the load cycle.
REQ-039 Terminal event with clr_ovf=1 in the same cycle -> ovf=1; clr_ovf=1 alone next cycle -> ovf=0.
REQ-040 reset=1 with load=1, en=1, q=7 -> q=0 and ovf=0 next edge; tc=0 while reset=1.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter.
//   CNT_WRAP / CNT_SAT : the two behaviours at the ends of the count range
//   modulus_ok()       : tells whether a MODULUS value is legal for a given WIDTH
package counter_pkg;

   localparam int CNT_WRAP = 0;
   localparam int CNT_SAT  = 1;

   // The range 0..MODULUS-1 has to contain at least two values, and
   // MODULUS-1 has to fit in WIDTH bits.
   function automatic bit modulus_ok(input int width, input longint modulus);
      longint full_range;
      full_range = longint'(1) << width;
      return (modulus >= 2) && (modulus <= full_range);
   endfunction

endpackage

// File: rtl/mod_next_value.sv
// Next-count logic for mod_updown_counter (purely combinational).
//   q        : current registered count
//   up       : direction, 1 = increment, 0 = decrement
//   en       : count enable
//   load     : parallel load strobe, takes priority over en
//   load_val : parallel load value, clamped to MODULUS-1
//   q_next   : value for the count register at the next edge
//   term     : a terminal (wrap/saturate) event happens at the next edge
module mod_next_value
   import counter_pkg::*;
#(
   parameter int     WIDTH    = 8,
   parameter longint MODULUS  = longint'(1) << WIDTH,
   parameter int     SATURATE = CNT_WRAP
) (
   input  logic [WIDTH-1:0] q,
   input  logic             up,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q_next,
   output logic             term
);

   // Carry one extra bit so the compare against MODULUS-1 and the +1 step
   // never depend on WIDTH-bit rollover when MODULUS < 2**WIDTH.
   localparam longint         MAX_L = MODULUS - 1;
   localparam logic [WIDTH:0] MAX_V = MAX_L[WIDTH:0];
   localparam logic [WIDTH:0] ZERO  = '0;
   localparam logic [WIDTH:0] ONE   = {{WIDTH{1'b0}}, 1'b1};

   logic [WIDTH:0] q_ext;
   logic [WIDTH:0] lv_ext;
   logic [WIDTH:0] nxt;
   logic           unused_msb;

   assign q_ext  = {1'b0, q};
   assign lv_ext = {1'b0, load_val};

   always_comb begin
      nxt  = q_ext;
      term = 1'b0;
      if (load) begin
         nxt = (lv_ext > MAX_V) ? MAX_V : lv_ext;
      end else if (en) begin
         if (up) begin
            if (q_ext == MAX_V) begin
               term = 1'b1;
               nxt  = (SATURATE == CNT_SAT) ? MAX_V : ZERO;
            end else begin
               nxt = q_ext + ONE;
            end
         end else begin
            if (q_ext == ZERO) begin
               term = 1'b1;
               nxt  = (SATURATE == CNT_SAT) ? ZERO : MAX_V;
            end else begin
               nxt = q_ext - ONE;
            end
         end
      end
   end

   // nxt never exceeds MAX_V, so its top bit is always zero.
   assign q_next     = nxt[WIDTH-1:0];
   assign unused_msb = nxt[WIDTH];

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with parallel load, cascade lookahead and a
// sticky overflow/underflow flag.
//   clk      : clock, rising edge
//   reset    : synchronous, active-high; clears q and ovf
//   en       : count enable
//   up       : direction, 1 = increment, 0 = decrement
//   load     : parallel load strobe (load_val clamped to MODULUS-1)
//   load_val : parallel load value
//   clr_ovf  : clears ovf at the next edge; a simultaneous terminal event wins
//   q        : registered count, 0..MODULUS-1
//   tc       : combinational terminal-count lookahead for cascading
//   ovf      : registered sticky overflow/underflow flag
module mod_updown_counter
   import counter_pkg::*;
#(
   parameter int     WIDTH    = 8,
   parameter longint MODULUS  = longint'(1) << WIDTH,
   parameter int     SATURATE = CNT_WRAP
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             ovf
);

   generate
      if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
         $error("mod_updown_counter: WIDTH must be 1..32");
      end
      if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
         $error("mod_updown_counter: MODULUS must be 2..2**WIDTH");
      end
      if (SATURATE != CNT_WRAP && SATURATE != CNT_SAT) begin : g_bad_sat
         $error("mod_updown_counter: SATURATE must be 0 or 1");
      end
   endgenerate

   logic [WIDTH-1:0] q_next;
   logic             term;

   mod_next_value #(
      .WIDTH    (WIDTH),
      .MODULUS  (MODULUS),
      .SATURATE (SATURATE)
   ) u_next (
      .q        (q),
      .up       (up),
      .en       (en),
      .load     (load),
      .load_val (load_val),
      .q_next   (q_next),
      .term     (term)
   );

   // term is already gated by en and ~load; reset masks it so a cascaded
   // stage never sees a carry while this stage is being cleared.
   assign tc = term & ~reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         q   <= '0;
         ovf <= 1'b0;
      end else begin
         q <= q_next;
         if (term) begin
            ovf <= 1'b1;
         end else if (clr_ovf) begin
            ovf <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mod_updown_counter.sv
module tb_mod_updown_counter;
   import counter_pkg::*;

   logic       clk = 1'b0;
   logic       reset, en, up, load, clr_ovf;
   logic [3:0] load_val;
   logic [3:0] q_w, q_s;
   logic       tc_w, tc_s, ovf_w, ovf_s;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(CNT_WRAP)) u_wrap (
      .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
      .load_val(load_val), .clr_ovf(clr_ovf), .q(q_w), .tc(tc_w), .ovf(ovf_w)
   );

   mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(CNT_SAT)) u_sat (
      .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
      .load_val(load_val), .clr_ovf(clr_ovf), .q(q_s), .tc(tc_s), .ovf(ovf_s)
   );

   // Advance one rising edge, then settle 1 ns past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset = 0; en = 0; up = 1; load = 0; load_val = 0; clr_ovf = 0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1;
      step();
      reset = 0;
   endtask

   task automatic test_reset();
      idle();
      reset = 1; load = 1; load_val = 4'd7; en = 1;
      #1;
      checks++;
      if (tc_w !== 1'b0) begin
         errors++; $display("FAIL reset_tc got %0b exp 0", tc_w);
      end
      step();
      checks++;
      if (q_w !== 4'd0 || ovf_w !== 1'b0) begin
         errors++; $display("FAIL reset_state got q=%0d ovf=%0b exp q=0 ovf=0", q_w, ovf_w);
      end
      checks++;
      if (q_s !== 4'd0 || ovf_s !== 1'b0) begin
         errors++; $display("FAIL reset_state_sat got q=%0d ovf=%0b exp q=0 ovf=0", q_s, ovf_s);
      end
      idle();
   endtask

   task automatic test_count_up();
      int ew, es;
      do_reset();
      en = 1; up = 1;
      for (int i = 0; i < 12; i++) begin
         #1;
         checks++;
         if (tc_w !== ((i % 10) == 9)) begin
            errors++; $display("FAIL up_tc i=%0d got %0b exp %0b", i, tc_w, (i % 10) == 9);
         end
         step();
         ew = (i + 1) % 10;
         es = (i + 1 > 9) ? 9 : i + 1;
         checks++;
         if (q_w !== 4'(ew) || ovf_w !== (i + 1 >= 10)) begin
            errors++; $display("FAIL up_wrap i=%0d got q=%0d ovf=%0b exp q=%0d ovf=%0b",
                               i, q_w, ovf_w, ew, i + 1 >= 10);
         end
         checks++;
         if (q_s !== 4'(es) || ovf_s !== (i + 1 >= 10)) begin
            errors++; $display("FAIL up_sat i=%0d got q=%0d ovf=%0b exp q=%0d ovf=%0b",
                               i, q_s, ovf_s, es, i + 1 >= 10);
         end
      end
      idle();
   endtask

   task automatic test_count_down();
      do_reset();
      en = 1; up = 0;
      #1;
      checks++;
      if (tc_w !== 1'b1 || tc_s !== 1'b1) begin
         errors++; $display("FAIL down_tc got w=%0b s=%0b exp 1 1", tc_w, tc_s);
      end
      step();
      checks++;
      if (q_w !== 4'd9 || ovf_w !== 1'b1) begin
         errors++; $display("FAIL down_wrap got q=%0d ovf=%0b exp q=9 ovf=1", q_w, ovf_w);
      end
      checks++;
      if (q_s !== 4'd0 || ovf_s !== 1'b1) begin
         errors++; $display("FAIL down_sat got q=%0d ovf=%0b exp q=0 ovf=1", q_s, ovf_s);
      end
      step();
      checks++;
      if (q_w !== 4'd8) begin
         errors++; $display("FAIL down_step got q=%0d exp 8", q_w);
      end
      idle();
   endtask

   task automatic test_saturate();
      do_reset();
      load = 1; load_val = 4'd9;
      step();
      load = 0; en = 1; up = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (tc_s !== 1'b1) begin
            errors++; $display("FAIL sat_tc i=%0d got %0b exp 1", i, tc_s);
         end
         step();
         checks++;
         if (q_s !== 4'd9 || ovf_s !== 1'b1) begin
            errors++; $display("FAIL sat_hold i=%0d got q=%0d ovf=%0b exp q=9 ovf=1", i, q_s, ovf_s);
         end
      end
      idle();
   endtask

   task automatic test_load_clamp();
      do_reset();
      load = 1; load_val = 4'd9;
      step();
      // q=9 with en&up would be terminal, but load must mask it.
      load = 1; load_val = 4'd13; en = 1; up = 1;
      #1;
      checks++;
      if (tc_w !== 1'b0) begin
         errors++; $display("FAIL load_tc got %0b exp 0", tc_w);
      end
      step();
      checks++;
      if (q_w !== 4'd9 || ovf_w !== 1'b0) begin
         errors++; $display("FAIL load_clamp got q=%0d ovf=%0b exp q=9 ovf=0", q_w, ovf_w);
      end
      load = 1; load_val = 4'd4; en = 0;
      step();
      checks++;
      if (q_w !== 4'd4) begin
         errors++; $display("FAIL load_plain got q=%0d exp 4", q_w);
      end
      idle();
   endtask

   task automatic test_clr_ovf();
      do_reset();
      load = 1; load_val = 4'd9;
      step();
      load = 0; en = 1; up = 1; clr_ovf = 1;
      step();
      checks++;
      if (ovf_w !== 1'b1 || q_w !== 4'd0) begin
         errors++; $display("FAIL clr_set_wins got q=%0d ovf=%0b exp q=0 ovf=1", q_w, ovf_w);
      end
      en = 0; clr_ovf = 0;
      step();
      checks++;
      if (ovf_w !== 1'b1 || q_w !== 4'd0) begin
         errors++; $display("FAIL hold got q=%0d ovf=%0b exp q=0 ovf=1", q_w, ovf_w);
      end
      clr_ovf = 1;
      step();
      checks++;
      if (ovf_w !== 1'b0 || q_w !== 4'd0) begin
         errors++; $display("FAIL clr_alone got q=%0d ovf=%0b exp q=0 ovf=0", q_w, ovf_w);
      end
      idle();
   endtask

   task automatic test_reset_midcount();
      do_reset();
      en = 1; up = 0;
      step();
      en = 0; load = 1; load_val = 4'd7;
      step();
      checks++;
      if (q_w !== 4'd7 || ovf_w !== 1'b1) begin
         errors++; $display("FAIL pre_reset got q=%0d ovf=%0b exp q=7 ovf=1", q_w, ovf_w);
      end
      reset = 1; load = 1; en = 1; up = 1;
      step();
      checks++;
      if (q_w !== 4'd0 || ovf_w !== 1'b0) begin
         errors++; $display("FAIL mid_reset got q=%0d ovf=%0b exp q=0 ovf=0", q_w, ovf_w);
      end
      // q=0, down, enabled: terminal if not for reset
      load = 0; up = 0;
      #1;
      checks++;
      if (tc_w !== 1'b0) begin
         errors++; $display("FAIL reset_masks_tc got %0b exp 0", tc_w);
      end
      step();
      reset = 0;
      step();
      checks++;
      if (q_w !== 4'd9 || ovf_w !== 1'b1) begin
         errors++; $display("FAIL resume got q=%0d ovf=%0b exp q=9 ovf=1", q_w, ovf_w);
      end
      idle();
   endtask

   task automatic test_back_to_back();
      do_reset();
      load = 1; load_val = 4'd5;
      step();
      load = 0; en = 1; up = 1;
      step();
      checks++;
      if (q_w !== 4'd6) begin
         errors++; $display("FAIL dir_up got q=%0d exp 6", q_w);
      end
      up = 0;
      step();
      checks++;
      if (q_w !== 4'd5) begin
         errors++; $display("FAIL dir_down got q=%0d exp 5", q_w);
      end
      up = 1;
      step();
      checks++;
      if (q_w !== 4'd6 || ovf_w !== 1'b0) begin
         errors++; $display("FAIL dir_up2 got q=%0d ovf=%0b exp q=6 ovf=0", q_w, ovf_w);
      end
      idle();
   endtask

   initial begin
      idle();
      #2;
      test_reset();
      test_count_up();
      test_count_down();
      test_saturate();
      test_load_clamp();
      test_clr_ovf();
      test_reset_midcount();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
